piso_serializer: RTL and testbench

//   Parallel-in serial-out transmitter: accepts a WIDTH-bit word on a load handshake
//   and shifts it out one bit per Clock on Q, with a bit-valid strobe and end-of-word pulse.
//   It is the transmit end of the team's serial bit-stream link and feeds the 6-bit

---
 rtl/piso_serializer_pkg.sv | 12 +
 rtl/piso_serializer_bit_down_counter.sv | 27 ++
 rtl/piso_serializer.sv | 96 +++++++++
 tb/tb_piso_serializer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serial bit-stream link: state encodings and the
// default word width used by the transmitter and the 6-bit receiver.
package piso_serializer_pkg;

  localparam int DSD_WORD_W = 6;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } st_e;

endpackage

// File: rtl/piso_serializer_bit_down_counter.sv
// Loadable down-counter that tracks the bits still to be sent after the one on Q.
// It saturates at zero and flags it.
module piso_serializer_bit_down_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          zero
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: one word per Load/Ready handshake,
// shifted out one bit per clock on Q with Valid and an end-of-word Done strobe.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = DSD_WORD_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] Data,
  input  logic             Load,
  output logic             Ready,
  output logic             Q,
  output logic             Valid,
  output logic             Done,
  output st_e              dbg_state
);

  localparam int CW = $clog2(WIDTH);

  // Handshake: a word is taken at the posedge where Load && Ready. Ready is
  // decoded from registers only, so it never depends on Load combinationally.
  st_e              state_q, state_n;
  logic [WIDTH-1:0] sh_q, sh_n;
  logic             q_n, valid_n, done_n;
  logic [CW-1:0]    count;
  logic             zero;
  logic             accept;
  logic             shift_en;

  assign Ready     = (state_q == ST_IDLE) || zero;
  assign accept    = Load && Ready;
  assign shift_en  = (state_q == ST_SHIFT) && !zero;
  assign dbg_state = state_q;

  piso_serializer_bit_down_counter #(.CW(CW)) u_cnt (
    .clk      (Clock),
    .rstn     (Resetn),
    .load     (accept),
    .load_val (CW'(WIDTH - 1)),
    .dec      (shift_en),
    .count    (count),
    .zero     (zero)
  );

  // sh_q holds only the bits not yet presented, aligned so the next one sits
  // at the outgoing end; the first bit goes straight from Data to Q.
  always_comb begin
    state_n = state_q;
    sh_n    = sh_q;
    q_n     = 1'b0;
    valid_n = 1'b0;
    done_n  = 1'b0;
    if (accept) begin
      state_n = ST_SHIFT;
      valid_n = 1'b1;
      if (MSB_FIRST) begin
        q_n  = Data[WIDTH-1];
        sh_n = Data << 1;
      end else begin
        q_n  = Data[0];
        sh_n = Data >> 1;
      end
    end else if (shift_en) begin
      valid_n = 1'b1;
      done_n  = (count == CW'(1));
      if (MSB_FIRST) begin
        q_n  = sh_q[WIDTH-1];
        sh_n = sh_q << 1;
      end else begin
        q_n  = sh_q[0];
        sh_n = sh_q >> 1;
      end
    end else begin
      state_n = ST_IDLE;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      Q       <= 1'b0;
      Valid   <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_n;
      sh_q    <= sh_n;
      Q       <= q_n;
      Valid   <= valid_n;
      Done    <= done_n;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share inputs and
// are compared every cycle against a bit-queue model, plus literal stream checks.
module tb_piso_serializer;
  import piso_serializer_pkg::*;

  localparam int W = 6;

  logic         Clock = 1'b0;
  logic         Resetn = 1'b0;
  logic         Load = 1'b0;
  logic [W-1:0] Data = '0;
  logic         q[2], valid[2], done[2], ready[2];
  st_e          st[2];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 Clock = ~Clock;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .Clock(Clock), .Resetn(Resetn), .Data(Data), .Load(Load), .Ready(ready[0]),
    .Q(q[0]), .Valid(valid[0]), .Done(done[0]), .dbg_state(st[0])
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .Clock(Clock), .Resetn(Resetn), .Data(Data), .Load(Load), .Ready(ready[1]),
    .Q(q[1]), .Valid(valid[1]), .Done(done[1]), .dbg_state(st[1])
  );

  // Model: a queue of bits still to be shown; a word is accepted when nothing
  // is pending, and each cycle shows the next queued bit.
  bit mq[2][$];
  bit m_q[2], m_v[2], m_d[2];

  always @(posedge Clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!Resetn) begin
        mq[i].delete();
        m_q[i] = 1'b0; m_v[i] = 1'b0; m_d[i] = 1'b0;
      end else begin
        if (Load && mq[i].size() == 0)
          for (int k = 0; k < W; k++) mq[i].push_back(i == 0 ? Data[W-1-k] : Data[k]);
        if (mq[i].size() > 0) begin
          m_q[i] = mq[i].pop_front();
          m_v[i] = 1'b1;
          m_d[i] = (mq[i].size() == 0);
        end else begin
          m_q[i] = 1'b0; m_v[i] = 1'b0; m_d[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (q[i] !== m_q[i] || valid[i] !== m_v[i] || done[i] !== m_d[i] ||
            ready[i] !== (mq[i].size() == 0) || (st[i] == ST_SHIFT) !== m_v[i]) begin
          n_fail++;
          $display("FAIL cycle_cmp[%0d] t=%0t got q=%b v=%b d=%b r=%b st=%b exp q=%b v=%b d=%b r=%b",
                   i, $time, q[i], valid[i], done[i], ready[i], st[i],
                   m_q[i], m_v[i], m_d[i], (mq[i].size() == 0));
        end
      end
    end
  end

  // Recorder of the serial streams for literal checks.
  logic [31:0] rec[2];
  int nv[2], nd[2], nr[2];

  always @(negedge Clock) begin
    for (int i = 0; i < 2; i++) begin
      if (valid[i] === 1'b1) begin
        rec[i] = {rec[i][30:0], q[i]};
        nv[i]++;
        if (ready[i] === 1'b0) nr[i]++;
      end
      if (done[i] === 1'b1) nd[i]++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic clear_rec();
    @(negedge Clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      rec[i] = '0; nv[i] = 0; nd[i] = 0; nr[i] = 0;
    end
  endtask

  task automatic load_word(input logic [W-1:0] d);
    @(negedge Clock);
    Load = 1'b1;
    Data = d;
    @(negedge Clock);
    Load = 1'b0;
    Data = W'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    bit seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge Clock);
      #1;
      if (valid[0] !== 1'b1 && valid[1] !== 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wait_idle_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge Clock);
      #1;
      if (done[0] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wait_done_timeout", 32'(seen), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rec[i] = '0; nv[i] = 0; nd[i] = 0; nr[i] = 0;
    end
    // Reset held for two edges with Load asserted: no word may start.
    Resetn = 1'b0;
    Load   = 1'b1;
    Data   = 6'b111111;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    Load   = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("reset_outputs", {28'd0, q[0], valid[0], done[0], ready[0]}, 32'b0001);
    @(negedge Clock);
    #1;
    chk("reset_no_word", {31'd0, valid[0]}, 32'd0);

    // Single word MSB-first; LSB instance sends the mirrored bit order.
    clear_rec();
    load_word(6'b101101);
    wait_idle(20);
    chk("w101101_msb", rec[0], 32'b101101);
    chk("w101101_lsb", rec[1], 32'b101101);
    chk("w101101_nvalid", nv[0], 6);
    chk("w101101_ndone", nd[0], 1);
    chk("w101101_notready", nr[0], 5);

    // Back-to-back: second load in the Done cycle.
    clear_rec();
    load_word(6'b110011);
    wait_done(20);
    Load = 1'b1;
    Data = 6'b001110;
    @(negedge Clock);
    Load = 1'b0;
    wait_idle(20);
    chk("b2b_stream", rec[0], 32'b110011001110);
    chk("b2b_nvalid", nv[0], 12);
    chk("b2b_ndone", nd[0], 2);

    // Load while busy is ignored.
    clear_rec();
    load_word(6'b010101);
    repeat (3) @(negedge Clock);
    Load = 1'b1;
    Data = 6'b111111;
    @(negedge Clock);
    Load = 1'b0;
    wait_idle(20);
    chk("busy_load_ignored", rec[0], 32'b010101);
    chk("busy_load_nvalid", nv[0], 6);

    // Reset mid-word aborts it without a Done pulse.
    clear_rec();
    load_word(6'b100001);
    repeat (2) @(negedge Clock);
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    #1;
    chk("abort_outputs", {28'd0, q[0], valid[0], done[0], ready[0]}, 32'b0001);
    chk("abort_no_done", nd[0], 0);
    clear_rec();
    load_word(6'b011010);
    wait_idle(20);
    chk("after_abort_stream", rec[0], 32'b011010);
    chk("after_abort_ndone", nd[0], 1);

    // LSB-first ordering.
    clear_rec();
    load_word(6'b000011);
    wait_idle(20);
    chk("lsb_first_stream", rec[1], 32'b110000);
    chk("msb_first_stream", rec[0], 32'b000011);

    // Randomized traffic with occasional resets, checked by the model.
    repeat (400) begin
      @(negedge Clock);
      Load   = ($urandom_range(0, 2) != 0);
      Data   = W'($urandom);
      Resetn = ($urandom_range(0, 49) != 0);
    end
    @(negedge Clock);
    Load   = 1'b0;
    Resetn = 1'b1;
    wait_idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
